// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-back write-allocate L1 data cache controller
//
// Purpose:
//   MEM-stage data cache. Hits are served in the request cycle. A miss freezes
//   the pipeline through stall_o while the victim line is written back (if
//   dirty) and the requested line is refilled from line-wide backing memory.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   memRead_i, memWrite_i  load / store request from EX/MEM (write wins if both)
//   addr_i, wdata_i        byte address and store data
//   rdata_o                load data (0 unless the access is a read hit)
//   stall_o                pipeline freeze while a miss is outstanding
//   mem_enable_o           backing-memory request, held until mem_ack_i
//   mem_write_o            1 = line writeback, 0 = line refill
//   mem_addr_o             line address (low 4 bits zero)
//   mem_data_o             line being written back
//   mem_data_i             refill line
//   mem_ack_i              one-cycle completion pulse
module dcache_ctrl #(
  parameter int IDX_W = 4,
  parameter int TAG_W = 24
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         memRead_i,
  input  logic         memWrite_i,
  input  logic [31:0]  addr_i,
  input  logic [31:0]  wdata_i,
  output logic [31:0]  rdata_o,
  output logic         stall_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [127:0] mem_data_o,
  input  logic [127:0] mem_data_i,
  input  logic         mem_ack_i
);

  localparam int LINES = 1 << IDX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  state_t state;

  // Valid/dirty are reset; tag and data arrays deliberately are not.
  logic [LINES-1:0] validQ;
  logic [LINES-1:0] dirtyQ;
  logic [TAG_W-1:0] tagMem  [LINES];
  logic [127:0]     dataMem [LINES];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] addrTag;
  logic [1:0]       wordSel;
  logic             req;
  logic             isWrite;
  logic             isRead;
  logic             hit;
  logic [1:0]       unusedAddrBits;

  assign idx            = addr_i[3+IDX_W:4];
  assign addrTag        = addr_i[31:4+IDX_W];
  assign wordSel        = addr_i[3:2];
  assign unusedAddrBits = addr_i[1:0];

  assign req     = memRead_i | memWrite_i;
  assign isWrite = memWrite_i;
  // A simultaneous read+write is a write, so it never returns load data.
  assign isRead  = memRead_i & ~memWrite_i;
  assign hit     = validQ[idx] & (tagMem[idx] == addrTag);

  // rdata_o and stall_o must react in the request cycle, so they are
  // decoded combinationally from the registered state.
  always_comb begin
    rdata_o = '0;
    stall_o = 1'b0;
    case (state)
      IDLE: begin
        if (req && !hit) stall_o = 1'b1;
        if (isRead && hit) rdata_o = dataMem[idx][{wordSel, 5'b0} +: 32];
      end
      WRITEBACK: stall_o = 1'b1;
      ALLOCATE:  stall_o = 1'b1;
      default:   stall_o = 1'b0;
    endcase
  end

  // Memory-side outputs are registered and only change on a state
  // transition, which keeps them stable from request until ack.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      validQ       <= '0;
      dirtyQ       <= '0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (hit) begin
              if (isWrite) begin
                dataMem[idx][{wordSel, 5'b0} +: 32] <= wdata_i;
                dirtyQ[idx]                         <= 1'b1;
              end
            end else if (validQ[idx] && dirtyQ[idx]) begin
              state        <= WRITEBACK;
              mem_enable_o <= 1'b1;
              mem_write_o  <= 1'b1;
              mem_addr_o   <= {tagMem[idx], idx, 4'b0};
              mem_data_o   <= dataMem[idx];
            end else begin
              state        <= ALLOCATE;
              mem_enable_o <= 1'b1;
              mem_write_o  <= 1'b0;
              mem_addr_o   <= {addr_i[31:4], 4'b0};
              mem_data_o   <= '0;
            end
          end
        end

        WRITEBACK: begin
          // Moving to refill is a fresh request: enable stays high,
          // write drops and the address switches to the new line.
          if (mem_ack_i) begin
            dirtyQ[idx]  <= 1'b0;
            state        <= ALLOCATE;
            mem_enable_o <= 1'b1;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= {addr_i[31:4], 4'b0};
            mem_data_o   <= '0;
          end
        end

        ALLOCATE: begin
          if (mem_ack_i) begin
            dataMem[idx] <= mem_data_i;
            tagMem[idx]  <= addrTag;
            validQ[idx]  <= 1'b1;
            dirtyQ[idx]  <= 1'b0;
            state        <= IDLE;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
          end
        end

        default: begin
          state        <= IDLE;
          mem_enable_o <= 1'b0;
          mem_write_o  <= 1'b0;
          mem_addr_o   <= '0;
          mem_data_o   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - self-checking bench for dcache_ctrl
module tb_dcache_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         memRead;
  logic         memWrite;
  logic [31:0]  addr;
  logic [31:0]  wdata;
  logic [31:0]  rdata;
  logic         stall;
  logic         memEnable;
  logic         memWriteO;
  logic [31:0]  memAddr;
  logic [127:0] memDataOut;
  logic [127:0] memDataIn;
  logic         memAck;

  always #5 clk = ~clk;

  dcache_ctrl #(.IDX_W(4), .TAG_W(24)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .memRead_i    (memRead),
    .memWrite_i   (memWrite),
    .addr_i       (addr),
    .wdata_i      (wdata),
    .rdata_o      (rdata),
    .stall_o      (stall),
    .mem_enable_o (memEnable),
    .mem_write_o  (memWriteO),
    .mem_addr_o   (memAddr),
    .mem_data_o   (memDataOut),
    .mem_data_i   (memDataIn),
    .mem_ack_i    (memAck)
  );

  int cmpCnt = 0;
  int errCnt = 0;

  // Backing memory (line address -> line) and architectural word overrides
  // for stores that may still live only in the cache.
  logic [127:0] bmem [int];
  logic [31:0]  arch [int];

  // Cache occupancy model: which tag each index holds and whether it is dirty.
  int cTag   [16];
  bit cValid [16];
  bit cDirty [16];

  typedef struct {
    bit          wr;
    logic [31:0] a;
  } txn_t;
  txn_t txLog[$];

  int wbDelay = 0;
  int rfDelay = 0;
  bit respOn  = 1'b1;
  int waitCnt = 0;

  function automatic logic [127:0] initLine(input logic [31:0] la);
    return {la ^ 32'hC0DE_0003, la ^ 32'hC0DE_0002, la ^ 32'hC0DE_0001, la ^ 32'hC0DE_0000};
  endfunction

  function automatic logic [127:0] getLine(input logic [31:0] la);
    if (bmem.exists(int'(la))) return bmem[int'(la)];
    return initLine(la);
  endfunction

  function automatic logic [31:0] archWord(input logic [31:0] a);
    logic [127:0] ln;
    int wa;
    wa = int'({a[31:2], 2'b00});
    if (arch.exists(wa)) return arch[wa];
    ln = getLine({a[31:4], 4'b0});
    return ln[{a[3:2], 5'b0} +: 32];
  endfunction

  // Backing-memory responder: acks after the programmed number of wait
  // cycles, stores writebacks and supplies refill lines.
  always @(negedge clk) begin
    if (respOn) begin
      memAck = 1'b0;
      if (memEnable && !rst) begin
        if (waitCnt >= (memWriteO ? wbDelay : rfDelay)) begin
          memAck  = 1'b1;
          waitCnt = 0;
          txLog.push_back('{memWriteO, memAddr});
          if (memWriteO) bmem[int'(memAddr)] = memDataOut;
          else           memDataIn = getLine(memAddr);
        end else begin
          waitCnt++;
        end
      end else begin
        waitCnt = 0;
      end
    end else begin
      waitCnt = 0;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    cmpCnt++;
    assert (obs === exp) else begin
      errCnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) begin
      cValid[i] = 1'b0;
      cDirty[i] = 1'b0;
    end
    arch.delete();
  endtask

  // One pipeline access, started just after a rising edge.
  task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    int   idx;
    int   tg;
    bit   miss;
    bit   wb;
    int   expStall;
    int   expN;
    int   stallCnt;
    txn_t expTx[2];
    idx  = int'((a >> 4) & 32'hF);
    tg   = int'(a >> 8);
    miss = !(cValid[idx] && cTag[idx] == tg);
    wb   = miss && cValid[idx] && cDirty[idx];
    expStall = miss ? (1 + (wb ? wbDelay + 1 : 0) + rfDelay + 1) : 0;
    expN = 0;
    if (wb) begin
      expTx[expN] = '{1'b1, (cTag[idx] << 8) | (idx << 4)};
      expN++;
    end
    if (miss) begin
      expTx[expN] = '{1'b0, {a[31:4], 4'b0}};
      expN++;
    end
    txLog.delete();
    memRead  = rd;
    memWrite = wr;
    addr     = a;
    wdata    = d;
    stallCnt = 0;
    @(negedge clk);
    while (stall === 1'b1 && stallCnt < 60) begin
      stallCnt++;
      @(negedge clk);
    end
    check("stall_cycles", stallCnt, expStall);
    if (rd && !wr) check("load_data", rdata, archWord(a));
    else           check("rdata_not_load", rdata, 32'h0);
    @(posedge clk);
    #1;
    memRead  = 1'b0;
    memWrite = 1'b0;
    check("txn_count", txLog.size(), expN);
    for (int k = 0; k < expN; k++) begin
      if (k < txLog.size()) begin
        check("txn_write", txLog[k].wr, expTx[k].wr);
        check("txn_addr", txLog[k].a, expTx[k].a);
      end
    end
    if (miss) begin
      cValid[idx] = 1'b1;
      cTag[idx]   = tg;
      cDirty[idx] = 1'b0;
    end
    if (wr) begin
      arch[int'({a[31:2], 2'b00})] = d;
      cDirty[idx] = 1'b1;
    end
  endtask

  task automatic idleCycle();
    memRead  = 1'b0;
    memWrite = 1'b0;
    @(negedge clk);
    check("idle_rdata", rdata, 32'h0);
    check("idle_stall", stall, 1'b0);
    check("idle_enable", memEnable, 1'b0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] line;
    logic [31:0]  ra;
    int           op;

    rst       = 1'b1;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    addr      = '0;
    wdata     = '0;
    memDataIn = '0;
    memAck    = 1'b0;
    modelReset();
    for (int i = 0; i < 16; i++) cTag[i] = 0;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall", stall, 1'b0);
    check("rst_enable", memEnable, 1'b0);
    check("rst_mem_write", memWriteO, 1'b0);
    check("rst_mem_addr", memAddr, 32'h0);
    check("rst_mem_data", memDataOut, 128'h0);
    check("rst_rdata", rdata, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Cold read with refill {D,C,B,A} acked after 3 wait cycles.
    bmem[32'h100] = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
    wbDelay = 0;
    rfDelay = 3;
    access(1'b1, 1'b0, 32'h0000_0104, 32'h0);

    // Write hit then read hit.
    access(1'b0, 1'b1, 32'h0000_0108, 32'hDEAD_BEEF);
    access(1'b1, 1'b0, 32'h0000_0108, 32'h0);
    idleCycle();

    // Dirty eviction: same index, new tag.
    wbDelay = 2;
    rfDelay = 1;
    access(1'b1, 1'b0, 32'h0000_1100, 32'h0);
    line = bmem[32'h100];
    check("wb_word2", line[95:64], 32'hDEAD_BEEF);
    check("wb_word1", line[63:32], 32'hBBBB_0001);

    // Clean eviction.
    wbDelay = 0;
    rfDelay = 0;
    access(1'b1, 1'b0, 32'h0000_2100, 32'h0);

    // Reset in the middle of a refill, followed by a late ack.
    respOn   = 1'b0;
    memRead  = 1'b1;
    addr     = 32'h0000_3200;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("alloc_enable", memEnable, 1'b1);
    check("alloc_mem_write", memWriteO, 1'b0);
    check("alloc_mem_addr", memAddr, 32'h0000_3200);
    rst     = 1'b1;
    memRead = 1'b0;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    memDataIn = {4{32'hBAD0_BAD0}};
    memAck    = 1'b1;
    @(negedge clk);
    check("midrst_enable", memEnable, 1'b0);
    check("midrst_stall", stall, 1'b0);
    @(posedge clk);
    #1;
    memAck = 1'b0;
    respOn = 1'b1;
    modelReset();
    rfDelay = 1;
    access(1'b1, 1'b0, 32'h0000_3200, 32'h0);

    // Read and write together on a cold miss: write-allocate.
    rfDelay = 2;
    access(1'b1, 1'b1, 32'h0000_0458, 32'h1234_5678);
    access(1'b1, 1'b0, 32'h0000_0458, 32'h0);
    access(1'b1, 1'b0, 32'h0000_0454, 32'h0);

    // Randomized traffic over a small address pool so lines collide.
    for (int n = 0; n < 250; n++) begin
      wbDelay = int'($urandom_range(0, 3));
      rfDelay = int'($urandom_range(0, 3));
      ra = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 4) |
           ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      op = int'($urandom_range(0, 3));
      case (op)
        0: idleCycle();
        1: access(1'b1, 1'b0, ra, 32'h0);
        2: access(1'b0, 1'b1, ra, $urandom);
        default: access(1'b1, 1'b1, ra, $urandom);
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache controller for the MEM stage.
- Consumes the request fields held in the EX/MEM pipeline register: read, write, address and store data.
- Returns load data, and drives stall_o to freeze the pipeline registers, including EX/MEM via its stall_i, while a miss is serviced.
- Connects to a slow line-wide backing memory through a level-request / ack handshake.

Parameters:
- IDX_W, 4: index bits; number of lines is 2^IDX_W.
- TAG_W, 24: tag bits; must equal 28-IDX_W.

Ports:
- clk_i  in  1  clock; all state changes on its rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- memRead_i  in  1  load request.
- memWrite_i  in  1  store request.
- addr_i  in  32  byte address. Bits [1:0] are ignored. Word select is [3:2], index is [3+IDX_W:4], tag is [31:4+IDX_W].
- wdata_i  in  32  store data.
- rdata_o  out  32  load data.
- stall_o  out  1  pipeline freeze.
- mem_enable_o  out  1  backing-memory request, held high until ack.
- mem_write_o  out  1  1 = line write, 0 = line read.
- mem_addr_o  out  32  line address; low 4 bits are always 0.
- mem_data_o  out  128  line being written back.
- mem_data_i  in  128  refill line.
- mem_ack_i  in  1  one-cycle completion pulse from backing memory.

Behaviour:
- Storage per line: valid, dirty, tag[TAG_W-1:0], data[127:0]. Word w of a line occupies bits [32w+31:32w].
- Request: req = memRead_i | memWrite_i. If both are high, the access is treated as a write.
- Hit (combinational): hit = valid[idx] & (tag[idx] == addr tag).
- Reset:
  - State goes to IDLE.
  - All valid and dirty bits are cleared.
  - stall_o, mem_enable_o, mem_write_o are 0; mem_addr_o and mem_data_o are 0; rdata_o is 0.
  - Tags and data are not cleared.
- State IDLE:
  - Read hit: rdata_o = selected word, same cycle (combinational); stall_o=0.
  - Write hit: stall_o=0. On the clock edge, the selected word is replaced with wdata_i and dirty[idx] is set to 1.
  - Miss with req: stall_o=1 combinationally.
    - Next state is WRITEBACK if valid[idx] & dirty[idx], else ALLOCATE.
  - No req: stall_o=0, rdata_o=0.
  - rdata_o is 0 whenever the access is not a read hit.
- State WRITEBACK:
  - mem_enable_o=1, mem_write_o=1.
  - mem_addr_o = {tag[idx], idx, 4'b0}; mem_data_o = data[idx].
  - stall_o=1.
  - On mem_ack_i: next state is ALLOCATE and dirty[idx] is cleared.
- State ALLOCATE:
  - mem_enable_o=1, mem_write_o=0, mem_addr_o = {addr_i[31:4], 4'b0}; stall_o=1.
  - On mem_ack_i: data[idx] = mem_data_i, tag[idx] = addr tag, valid[idx]=1, dirty[idx]=0; next state is IDLE.
- Miss completion:
  - In the cycle after refill, IDLE sees a hit, stall_o drops to 0 and the access completes as a normal hit.
  - Miss latency is 1 + (writeback ack cycles) + (refill ack cycles) + 1.
- Handshake rules:
  - mem_enable_o, mem_write_o, mem_addr_o and mem_data_o are stable from request until ack.
  - mem_enable_o drops or changes request in the cycle after ack.
  - WRITEBACK to ALLOCATE is a new request: mem_enable_o stays 1 and mem_write_o falls.
  - mem_ack_i in IDLE is ignored.
  - An ack in the same cycle as the request is accepted.
- Input stability: memRead_i, memWrite_i, addr_i and wdata_i are held stable by the frozen EX/MEM register whenever stall_o=1. The controller relies on this.
- Reset mid-miss: the miss is aborted. State returns to IDLE and mem_enable_o is 0 from the next cycle. A late ack is ignored and the line stays invalid.
- Reset priority: reset has priority over any simultaneous ack or write hit.

Test Plan:
- Cold read: reset, then read 0x0000_0104 with a refill returning {w3=D,w2=C,w1=B,w0=A} after 3 cycles.
  - Required response: stall_o high 5 cycles; one mem read at 0x0000_0100; rdata_o=B when stall_o falls.
- Write hit then read: write 0xDEADBEEF to 0x0000_0108, then read 0x0000_0108.
  - Required response: both complete with stall_o=0; rdata_o=0xDEADBEEF; dirty[0]=1.
- Dirty eviction: after the previous scenario, read 0x0000_1100 (same index 0, new tag).
  - Required response: mem write to 0x0000_0100 with w2=0xDEADBEEF, then mem read 0x0000_1100, then hit. The old line is not lost in memory.
- Clean eviction: read 0x0000_2100 after the previous scenario.
  - Required response: no writeback; a single mem read at 0x0000_2100.
- Reset mid-refill: assert rst_i while in ALLOCATE, then pulse mem_ack_i the next cycle.
  - Required response: mem_enable_o=0 and stall_o=0 after reset; a following read of the same address misses again.
- Read and write high together on a miss.
  - Required response: handled as a write-allocate. The line is filled, then the word is written and dirty is set.
